// File: rtl/dz_scan_if.sv
// rtl/dz_scan_if.sv - level input handshake and LED matrix drive bundle for dz_scan
interface dz_scan_if;
    logic [2:0] din;
    logic [1:0] din_color;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic       frame_done;

    modport master (
        output din, din_color, din_valid,
        input  din_ready, row, colr, colg, frame_done
    );

    modport slave (
        input  din, din_color, din_valid,
        output din_ready, row, colr, colg, frame_done
    );
endinterface

// File: rtl/dz_scan.sv
// rtl/dz_scan.sv - 8x8 bicolour bar-level matrix scanner with one-deep frame-synchronous input buffer
module dz_scan #(
    parameter logic [9:0] SCAN_DIV = 10'd125
) (
    input logic        clk,
    input logic        rst,
    dz_scan_if.slave   bus
);
    localparam logic [9:0] DIV_LAST = SCAN_DIV - 10'd1;

    logic [9:0] div_q, div_d;
    logic [2:0] ridx_q, ridx_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic       pend_full_q, pend_full_d;
    logic [2:0] pend_lvl_q, pend_lvl_d;
    logic [1:0] pend_col_q, pend_col_d;
    logic [2:0] shown_lvl_q, shown_lvl_d;
    logic [1:0] shown_col_q, shown_col_d;
    logic [7:0] row_q, row_d;
    logic [7:0] colr_q, colr_d;
    logic [7:0] colg_q, colg_d;
    logic       frame_done_q, frame_done_d;

    logic       row_edge;
    logic       frame_edge;
    logic [7:0] pattern;

    assign row_edge   = (div_q == DIV_LAST);
    assign frame_edge = row_edge && (ridx_q == 3'd7);

    assign bus.din_ready  = !pend_full_q;
    assign bus.row        = row_q;
    assign bus.colr       = colr_q;
    assign bus.colg       = colg_q;
    assign bus.frame_done = frame_done_q;

    // Next-state: scan counters, input slot, frame-synchronous display update and row pattern
    always_comb begin
        div_d        = div_q + 10'd1;
        ridx_d       = ridx_q;
        fcnt_d       = fcnt_q;
        pend_full_d  = pend_full_q;
        pend_lvl_d   = pend_lvl_q;
        pend_col_d   = pend_col_q;
        shown_lvl_d  = shown_lvl_q;
        shown_col_d  = shown_col_q;
        frame_done_d = frame_edge;

        if (row_edge) begin
            div_d  = 10'd0;
            ridx_d = ridx_q + 3'd1;
        end
        if (frame_edge) begin
            fcnt_d = fcnt_q + 4'd1;
        end

        // Display only swaps at the frame boundary so a frame is never torn
        if (frame_edge && pend_full_q) begin
            shown_lvl_d = pend_lvl_q;
            shown_col_d = pend_col_q;
            pend_full_d = 1'b0;
        end
        // Slot accepts only when empty, so it never collides with the swap above
        if (bus.din_valid && !pend_full_q) begin
            pend_lvl_d  = bus.din;
            pend_col_d  = bus.din_color;
            pend_full_d = 1'b1;
        end

        // Level N lights the bottom N rows; level 0 blinks the whole matrix every 8 frames
        if (shown_lvl_q != 3'd0) begin
            pattern = ({1'b0, ridx_q} >= (4'd8 - {1'b0, shown_lvl_q})) ? 8'hFF : 8'h00;
        end else begin
            pattern = fcnt_q[3] ? 8'hFF : 8'h00;
        end

        row_d  = ~(8'b1 << ridx_q);
        colr_d = pattern & {8{shown_col_q[0]}};
        colg_d = pattern & {8{shown_col_q[1]}};
    end

    // State and registered outputs; reset blanks the matrix and drops any pending value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= 10'd0;
            ridx_q       <= 3'd0;
            fcnt_q       <= 4'd0;
            pend_full_q  <= 1'b0;
            pend_lvl_q   <= 3'd0;
            pend_col_q   <= 2'b00;
            shown_lvl_q  <= 3'd0;
            shown_col_q  <= 2'b00;
            row_q        <= 8'hFF;
            colr_q       <= 8'h00;
            colg_q       <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            ridx_q       <= ridx_d;
            fcnt_q       <= fcnt_d;
            pend_full_q  <= pend_full_d;
            pend_lvl_q   <= pend_lvl_d;
            pend_col_q   <= pend_col_d;
            shown_lvl_q  <= shown_lvl_d;
            shown_col_q  <= shown_col_d;
            row_q        <= row_d;
            colr_q       <= colr_d;
            colg_q       <= colg_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_dz_scan.sv
// tb/tb_dz_scan.sv - self-checking bench for dz_scan with time-based reference model
module tb_dz_scan;
    localparam int D = 4;
    localparam int F = 8 * D;

    logic clk;
    logic rst;
    dz_scan_if bus();

    dz_scan #(.SCAN_DIV(10'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: state derived from cycles elapsed since reset release
    int         m_t;
    logic       m_pf;
    logic [2:0] m_pl;
    logic [1:0] m_pc;
    logic [2:0] m_sl;
    logic [1:0] m_sc;
    logic [7:0] e_row, e_colr, e_colg;
    logic       e_fd;

    typedef struct {
        logic [2:0] lvl;
        logic [1:0] col;
        logic [7:0] lit;
        logic       red;
        logic       grn;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%h expected=%h", name, m_t, act, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_pf = 1'b0; m_pl = 3'd0; m_pc = 2'b00; m_sl = 3'd0; m_sc = 2'b00;
        e_row = 8'hFF; e_colr = 8'h00; e_colg = 8'h00; e_fd = 1'b0;
    endtask

    task automatic model_step();
        int ridx, fcnt;
        logic [7:0] pat;
        logic take, bnd;
        if (rst) begin
            model_reset();
            return;
        end
        ridx = (m_t / D) % 8;
        fcnt = (m_t / F) % 16;
        if (m_sl != 3'd0) pat = (ridx >= 8 - int'(m_sl)) ? 8'hFF : 8'h00;
        else              pat = (fcnt >= 8) ? 8'hFF : 8'h00;
        e_row  = ~(8'b1 << ridx);
        e_colr = m_sc[0] ? pat : 8'h00;
        e_colg = m_sc[1] ? pat : 8'h00;
        bnd  = ((m_t % F) == F - 1);
        e_fd = bnd;
        take = bus.din_valid && !m_pf;
        if (bnd && m_pf) begin
            m_sl = m_pl; m_sc = m_pc; m_pf = 1'b0;
        end
        if (take) begin
            m_pl = bus.din; m_pc = bus.din_color; m_pf = 1'b1;
        end
        m_t++;
    endtask

    // One clock: model advances on the rising edge, DUT compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("mon_row", bus.row, e_row);
        chk("mon_colr", bus.colr, e_colr);
        chk("mon_colg", bus.colg, e_colg);
        chk("mon_frame_done", {7'd0, bus.frame_done}, {7'd0, e_fd});
        chk("mon_din_ready", {7'd0, bus.din_ready}, {7'd0, !m_pf});
    endtask

    task automatic wait_phase(input int ph);
        int guard = 0;
        while ((m_t % F) != ph) begin
            tick();
            guard++;
            if (guard > 200) begin
                chk("wait_phase_timeout", 8'd1, 8'd0);
                return;
            end
        end
    endtask

    task automatic send(input logic [2:0] lvl, input logic [1:0] col);
        wait_phase(12);
        bus.din = lvl; bus.din_color = col; bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        chk("send_ready_low", {7'd0, bus.din_ready}, 8'd0);
    endtask

    // Checks every cycle of the next whole frame against a lit-row mask
    task automatic check_frame(input logic [7:0] lit, input logic red, input logic grn, input logic blink);
        int guard = 0;
        int r, fr;
        logic [7:0] l;
        while (!(m_t >= 1 && ((m_t - 1) % F) == 0)) begin
            tick();
            guard++;
            if (guard > 200) begin
                chk("frame_sync_timeout", 8'd1, 8'd0);
                return;
            end
        end
        for (int i = 0; i < F; i++) begin
            if (i > 0) tick();
            r  = ((m_t - 1) / D) % 8;
            fr = ((m_t - 1) / F) % 16;
            l  = blink ? ((fr >= 8) ? 8'hFF : 8'h00) : lit;
            chk("frame_colr", bus.colr, (l[r] && red) ? 8'hFF : 8'h00);
            chk("frame_colg", bus.colg, (l[r] && grn) ? 8'hFF : 8'h00);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        vecs[0] = '{3'd3, 2'b01, 8'hE0, 1'b1, 1'b0};
        vecs[1] = '{3'd7, 2'b11, 8'hFE, 1'b1, 1'b1};
        vecs[2] = '{3'd1, 2'b10, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{3'd5, 2'b01, 8'hF8, 1'b1, 1'b0};
        vecs[4] = '{3'd6, 2'b00, 8'hFC, 1'b0, 1'b0};
        vecs[5] = '{3'd4, 2'b11, 8'hF0, 1'b1, 1'b1};

        rst = 1'b1;
        bus.din = 3'd0; bus.din_color = 2'b00; bus.din_valid = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_row", bus.row, 8'hFF);
        chk("rst_colr", bus.colr, 8'h00);
        chk("rst_colg", bus.colg, 8'h00);
        chk("rst_frame_done", {7'd0, bus.frame_done}, 8'd0);
        chk("rst_din_ready", {7'd0, bus.din_ready}, 8'd1);
        rst = 1'b0;

        // Idle scan: row walk every D cycles, frame_done once per 8*D cycles
        for (int i = 0; i < 2 * F; i++) begin
            logic [7:0] one;
            tick();
            one = 8'b1 << ((i / D) % 8);
            chk("walk_row", bus.row, ~one);
            chk("walk_fd", {7'd0, bus.frame_done}, ((i % F) == F - 1) ? 8'd1 : 8'd0);
            chk("walk_colr", bus.colr, 8'h00);
        end

        // Table of levels and colours, each sent mid-frame and checked over the next frame
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].lvl, vecs[v].col);
            check_frame(vecs[v].lit, vecs[v].red, vecs[v].grn, 1'b0);
            chk("ready_high", {7'd0, bus.din_ready}, 8'd1);
        end

        // Value held while the slot is full is only taken after the boundary
        send(3'd7, 2'b11);
        bus.din = 3'd2; bus.din_color = 2'b11; bus.din_valid = 1'b1;
        tick();
        chk("hold_ready_low", {7'd0, bus.din_ready}, 8'd0);
        wait_phase(1);
        bus.din_valid = 1'b0;
        check_frame(8'hFE, 1'b1, 1'b1, 1'b0);
        check_frame(8'hC0, 1'b1, 1'b1, 1'b0);

        // Transfer on the boundary cycle shows one frame later
        wait_phase(F - 1);
        bus.din = 3'd4; bus.din_color = 2'b01; bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        check_frame(8'hC0, 1'b1, 1'b1, 1'b0);
        check_frame(8'hF0, 1'b1, 1'b0, 1'b0);

        // Level 0 blinks green on an 8-frame half period
        send(3'd0, 2'b10);
        for (int f = 0; f < 16; f++) check_frame(8'h00, 1'b0, 1'b1, 1'b1);

        // Reset with a pending value discards it and restarts a blank scan
        send(3'd5, 2'b01);
        repeat (3) tick();
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_row", bus.row, 8'hFF);
        chk("midrst_colr", bus.colr, 8'h00);
        chk("midrst_colg", bus.colg, 8'h00);
        chk("midrst_ready", {7'd0, bus.din_ready}, 8'd1);
        repeat (2) tick();
        rst = 1'b0;
        check_frame(8'h00, 1'b1, 1'b1, 1'b0);
        check_frame(8'h00, 1'b1, 1'b1, 1'b0);

        // Random traffic with occasional resets, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            bus.din       = 3'($urandom);
            bus.din_color = 2'($urandom);
            bus.din_valid = ($urandom % 6) == 0;
            if (rst) rst = 1'b0;
            else if (($urandom % 700) == 0) begin
                rst = 1'b1;
                model_reset();
            end
            tick();
        end
        bus.din_valid = 1'b0;
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
